// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: RAW hazard detection with forwarding or decode stall, post-branch execute discard and stall counter
module hazard_fwd_unit #(
  parameter int NUM_STAGES   = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int FORWARD_EN   = 1,
  parameter int CNT_W        = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    branch_i,
  input  logic [4:0]              reg_raddr1_i,
  input  logic [4:0]              reg_raddr2_i,
  input  logic [NUM_STAGES-1:0]   stg_reg_write_i,
  input  logic [5*NUM_STAGES-1:0] stg_reg_addr_i,
  input  logic [NUM_STAGES-1:0]   stg_data_ready_i,
  input  logic                    stall_cnt_clear_i,
  output logic [NUM_STAGES-1:0]   fwd_sel1_o,
  output logic [NUM_STAGES-1:0]   fwd_sel2_o,
  output logic                    dec_stall_request_o,
  output logic                    ex_discard_request_o,
  output logic [CNT_W-1:0]        stall_cnt_o
);
  logic [3:0]            flush_cnt;
  logic [NUM_STAGES-1:0] m1, m2, y1, y2;
  logic                  s1, s2;
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_match
    assign m1[i] = stg_reg_write_i[i] && reg_raddr1_i != 5'd0 && reg_raddr1_i == stg_reg_addr_i[5*i +: 5];
    assign m2[i] = stg_reg_write_i[i] && reg_raddr2_i != 5'd0 && reg_raddr2_i == stg_reg_addr_i[5*i +: 5];
  end
  // Isolate the lowest set bit: the youngest matching stage wins
  assign y1 = m1 & (~m1 + NUM_STAGES'(1));
  assign y2 = m2 & (~m2 + NUM_STAGES'(1));
  assign s1 = |m1 && (FORWARD_EN == 0 || !(|(y1 & stg_data_ready_i)));
  assign s2 = |m2 && (FORWARD_EN == 0 || !(|(y2 & stg_data_ready_i)));
  assign ex_discard_request_o = branch_i || flush_cnt != 4'd0;
  assign dec_stall_request_o  = (s1 || s2) && !ex_discard_request_o;
  assign fwd_sel1_o = (s1 || dec_stall_request_o) ? '0 : y1;
  assign fwd_sel2_o = (s2 || dec_stall_request_o) ? '0 : y2;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) flush_cnt <= 4'd0;
    else if (branch_i) flush_cnt <= 4'(FLUSH_CYCLES - 1);
    else if (flush_cnt != 4'd0) flush_cnt <= flush_cnt - 4'd1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_o <= '0;
    else if (stall_cnt_clear_i) stall_cnt_o <= '0;
    else if (dec_stall_request_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
  end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: two configurations (forwarding/flush3/cnt4 and no-forwarding/flush1/cnt16) against a behavioural model
module tb_hazard_fwd_unit;
  logic        clk = 0, rst_n = 0, branch = 0, clr = 0;
  logic [4:0]  ra1 = 0, ra2 = 0;
  logic [3:0]  we = 0, rdy = 0;
  logic [19:0] addr = 0;
  logic [3:0]  sel1_a, sel2_a, sel1_b, sel2_b, cnt_a;
  logic [15:0] cnt_b;
  logic        st_a, st_b, dis_a, dis_b;
  int vectors = 0, miscompares = 0;
  int left[2] = '{0, 0};
  int cnt[2]  = '{0, 0};
  bit est[2];

  always #5 clk = ~clk;

  hazard_fwd_unit #(.NUM_STAGES(4), .FLUSH_CYCLES(3), .FORWARD_EN(1), .CNT_W(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .branch_i(branch), .reg_raddr1_i(ra1), .reg_raddr2_i(ra2),
    .stg_reg_write_i(we), .stg_reg_addr_i(addr), .stg_data_ready_i(rdy), .stall_cnt_clear_i(clr),
    .fwd_sel1_o(sel1_a), .fwd_sel2_o(sel2_a), .dec_stall_request_o(st_a),
    .ex_discard_request_o(dis_a), .stall_cnt_o(cnt_a));

  hazard_fwd_unit #(.NUM_STAGES(4), .FLUSH_CYCLES(1), .FORWARD_EN(0), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .branch_i(branch), .reg_raddr1_i(ra1), .reg_raddr2_i(ra2),
    .stg_reg_write_i(we), .stg_reg_addr_i(addr), .stg_data_ready_i(rdy), .stall_cnt_clear_i(clr),
    .fwd_sel1_o(sel1_b), .fwd_sel2_o(sel2_b), .dec_stall_request_o(st_b),
    .ex_discard_request_o(dis_b), .stall_cnt_o(cnt_b));

  function automatic int fc(int d);   return d == 0 ? 3 : 1;      endfunction
  function automatic int cmax(int d); return d == 0 ? 15 : 65535; endfunction

  task automatic chk(string tag, int d, string nm, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d %s observed %0h expected %0h", tag, d, nm, obs, exp);
    end
  endtask

  // Scan stages youngest-first; the first writer of this register decides forward vs stall
  task automatic opnd(input bit fe, input logic [4:0] ra, output bit st, output logic [3:0] sel);
    st = 0;
    sel = 0;
    if (ra != 0)
      for (int i = 0; i < 4; i++)
        if (we[i] && addr[5*i +: 5] == ra) begin
          if (fe && rdy[i]) sel = 4'(1 << i);
          else st = 1;
          break;
        end
  endtask

  task automatic check(string tag);
    for (int d = 0; d < 2; d++) begin
      bit s1, s2, disc, st;
      logic [3:0] e1, e2;
      opnd(d == 0, ra1, s1, e1);
      opnd(d == 0, ra2, s2, e2);
      disc = branch || left[d] != 0;
      st = (s1 || s2) && !disc;
      if (st) begin e1 = 0; e2 = 0; end
      est[d] = st;
      chk(tag, d, "sel1", d == 0 ? 32'(sel1_a) : 32'(sel1_b), 32'(e1));
      chk(tag, d, "sel2", d == 0 ? 32'(sel2_a) : 32'(sel2_b), 32'(e2));
      chk(tag, d, "stall", d == 0 ? 32'(st_a) : 32'(st_b), 32'(st));
      chk(tag, d, "discard", d == 0 ? 32'(dis_a) : 32'(dis_b), 32'(disc));
      chk(tag, d, "cnt", d == 0 ? 32'(cnt_a) : 32'(cnt_b), 32'(cnt[d]));
    end
  endtask

  task automatic step(string tag);
    #1 check(tag);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (clr) cnt[d] = 0;
      else if (est[d] && cnt[d] < cmax(d)) cnt[d]++;
      left[d] = branch ? fc(d) - 1 : (left[d] > 0 ? left[d] - 1 : 0);
    end
    #1;
  endtask

  task automatic hazard2();
    ra1 = 0; ra2 = 7; we = 4'b0101; addr = {5'd0, 5'd7, 5'd0, 5'd7}; rdy = 4'b0100;
  endtask

  initial begin
    #2 check("reset");
    rst_n = 1;
    ra1 = 5; we = 4'b1010; addr = {5'd5, 5'd0, 5'd5, 5'd0}; rdy = 4'b1010;
    #1 chk("t1", 0, "sel1", 32'(sel1_a), 32'(4'b0010));
    chk("t1", 0, "stall", 32'(st_a), 0);
    step("t1");
    hazard2();
    repeat (3) step("t2");
    chk("t2", 0, "stall", 32'(st_a), 1);
    chk("t2", 0, "sel2", 32'(sel2_a), 0);
    chk("t2", 0, "cnt", 32'(cnt_a), 3);
    ra2 = 0; ra1 = 3; we = 4'b1000; addr = {5'd3, 15'd0}; rdy = 4'b1000;
    #1 chk("t3", 1, "stall", 32'(st_b), 1);
    chk("t3", 1, "sel1", 32'(sel1_b), 0);
    chk("t3", 0, "sel1", 32'(sel1_a), 32'(4'b1000));
    step("t3");
    ra1 = 0; we = 4'b0001; addr = 0;
    #1 chk("t3_x0", 1, "stall", 32'(st_b), 0);
    step("t3_x0");
    hazard2();
    for (int k = 0; k < 5; k++) begin
      branch = (k == 0);
      #1 chk("t4_single", 0, "discard", 32'(dis_a), 32'(k < 3));
      step("t4_single");
    end
    for (int k = 0; k < 6; k++) begin
      branch = (k < 2);
      #1 chk("t4_reload", 0, "discard", 32'(dis_a), 32'(k < 4));
      if (k < 4) chk("t4_reload", 0, "stall", 32'(st_a), 0);
      step("t4_reload");
    end
    clr = 1; step("t5_clr");
    clr = 0;
    repeat (20) step("t5_sat");
    chk("t5_sat", 0, "cnt", 32'(cnt_a), 15);
    clr = 1; step("t5_clr_stall");
    clr = 0;
    chk("t5_clr_stall", 0, "cnt", 32'(cnt_a), 0);
    clr = 1; step("t6_pre");
    clr = 0;
    repeat (9) step("t6_pre");
    chk("t6_pre", 0, "cnt", 32'(cnt_a), 9);
    branch = 1; step("t6_branch");
    branch = 0;
    #3 rst_n = 0;
    left = '{0, 0};
    cnt = '{0, 0};
    #1 chk("t6_rst", 0, "discard", 32'(dis_a), 0);
    chk("t6_rst", 0, "cnt", 32'(cnt_a), 0);
    check("t6_rst");
    #2 rst_n = 1;
    #1 check("t6_rel");
    chk("t6_rel", 0, "discard", 32'(dis_a), 0);
    step("t6_after");
    repeat (400) begin
      branch = $urandom_range(0, 9) == 0;
      clr = $urandom_range(0, 19) == 0;
      ra1 = 5'($urandom_range(0, 3));
      ra2 = 5'($urandom_range(0, 3));
      we = 4'($urandom);
      rdy = 4'($urandom);
      for (int i = 0; i < 4; i++) addr[5*i +: 5] = 5'($urandom_range(0, 3));
      step("rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
